ysyx_25040101_lsu: RTL and testbench

//  Load/store unit directly downstream of the ALU. Takes the ALU result as the effective

---
 rtl/ysyx_25040101_pkg.sv | 35 +++
 rtl/ysyx_25040101_lsu_if.sv | 25 ++
 rtl/ysyx_25040101_lsu_align.sv | 52 +++++
 rtl/ysyx_25040101_lsu.sv | 143 ++++++++++++++
 tb/tb_ysyx_25040101_lsu.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25040101_pkg.sv
// Shared definitions for the ysyx_25040101 load/store unit: opcode fields,
// access size codes, FSM states, strobe base patterns and the alignment test.
package ysyx_25040101_pkg;

   localparam int unsigned LSU_DATA_W = 32;
   localparam int unsigned LSU_STRB_W = LSU_DATA_W / 8;

   // lsu_op bit positions: [3]=store, [2]=unsigned load, [1:0]=size
   localparam int unsigned LSU_OP_STORE    = 3;
   localparam int unsigned LSU_OP_UNSIGNED = 2;

   typedef enum logic [1:0] {
      LSU_SZ_B    = 2'b00,
      LSU_SZ_H    = 2'b01,
      LSU_SZ_W    = 2'b10,
      LSU_SZ_RSVD = 2'b11
   } lsu_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10,
      ST_DONE = 2'b11
   } lsu_state_e;

   localparam logic [LSU_STRB_W-1:0] LSU_STRB_B = 4'b0001;
   localparam logic [LSU_STRB_W-1:0] LSU_STRB_H = 4'b0011;
   localparam logic [LSU_STRB_W-1:0] LSU_STRB_WD = 4'b1111;

   // Halfword on an odd byte, or word not on a word boundary
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == LSU_SZ_H) && off[0]) || ((size == LSU_SZ_W) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/ysyx_25040101_lsu_if.sv
// Memory-side valid/ready bus of the LSU. master = LSU, slave = memory.
interface ysyx_25040101_lsu_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              mem_req_valid_o;
   logic              mem_req_ready_i;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_we_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [3:0]        mem_wstrb_o;
   logic              mem_resp_valid_i;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_resp_err_i;

   modport master (
      output mem_req_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o,
      input  mem_req_ready_i, mem_resp_valid_i, mem_rdata_i, mem_resp_err_i
   );

   modport slave (
      input  mem_req_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o,
      output mem_req_ready_i, mem_resp_valid_i, mem_rdata_i, mem_resp_err_i
   );
endinterface

// File: rtl/ysyx_25040101_lsu_align.sv
// Combinational byte-lane logic: store data/strobe shift and load extract/extend.
module ysyx_25040101_lsu_align
   import ysyx_25040101_pkg::*;
(
   input  logic [1:0]            st_off_i,
   input  logic [1:0]            st_size_i,
   input  logic [LSU_DATA_W-1:0] st_wdata_i,
   output logic [LSU_DATA_W-1:0] st_wdata_c_o,
   output logic [LSU_STRB_W-1:0] st_wstrb_c_o,
   input  logic [1:0]            ld_off_i,
   input  logic [1:0]            ld_size_i,
   input  logic                  ld_unsigned_i,
   input  logic [LSU_DATA_W-1:0] ld_rdata_i,
   output logic [LSU_DATA_W-1:0] ld_data_c_o
);

   logic [LSU_STRB_W-1:0] strb_base;
   logic [LSU_DATA_W-1:0] ld_shift;
   logic                  ld_sign;

   // Store: size pattern and data moved up to the addressed lanes, overflow dropped
   always_comb begin
      strb_base = '0;
      case (st_size_i)
         LSU_SZ_B: strb_base = LSU_STRB_B;
         LSU_SZ_H: strb_base = LSU_STRB_H;
         LSU_SZ_W: strb_base = LSU_STRB_WD;
         default:  strb_base = '0;
      endcase
      st_wstrb_c_o = LSU_STRB_W'(strb_base << st_off_i);
      st_wdata_c_o = LSU_DATA_W'(st_wdata_i << {st_off_i, 3'b000});
   end

   // Load: bring addressed byte to bit 0, then sign- or zero-extend by size
   always_comb begin
      ld_shift    = ld_rdata_i >> {ld_off_i, 3'b000};
      ld_sign     = 1'b0;
      ld_data_c_o = ld_shift;
      case (ld_size_i)
         LSU_SZ_B: begin
            ld_sign     = ~ld_unsigned_i & ld_shift[7];
            ld_data_c_o = {{24{ld_sign}}, ld_shift[7:0]};
         end
         LSU_SZ_H: begin
            ld_sign     = ~ld_unsigned_i & ld_shift[15];
            ld_data_c_o = {{16{ld_sign}}, ld_shift[15:0]};
         end
         default: ld_data_c_o = ld_shift;
      endcase
   end

endmodule

// File: rtl/ysyx_25040101_lsu.sv
// Load/store unit: one valid/ready memory access per execute request, result to writeback.
// Optional macro LSU_MISALIGN_CHECK_EN: fault misaligned H/W accesses without using the bus.
module ysyx_25040101_lsu
   import ysyx_25040101_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 ex_valid_i,
   output logic                 ex_ready_o,
   input  logic [ADDR_W-1:0]    addr_i,
   input  logic [DATA_W-1:0]    wdata_i,
   input  logic [3:0]           lsu_op_i,
   output logic                 wb_valid_o,
   input  logic                 wb_ready_i,
   output logic [DATA_W-1:0]    rdata_o,
   output logic                 err_o,
   ysyx_25040101_lsu_if.master  mem
);

   lsu_state_e        state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              ex_ready_q, ex_ready_d;
   logic              req_valid_q, req_valid_d;
   logic              wb_valid_q, wb_valid_d;
   logic              fault_c;
   logic [DATA_W-1:0] st_wdata_c;
   logic [3:0]        st_wstrb_c;
   logic [DATA_W-1:0] ld_data_c;

   ysyx_25040101_lsu_align u_align (
      .st_off_i      (addr_i[1:0]),
      .st_size_i     (lsu_op_i[1:0]),
      .st_wdata_i    (wdata_i),
      .st_wdata_c_o  (st_wdata_c),
      .st_wstrb_c_o  (st_wstrb_c),
      .ld_off_i      (off_q),
      .ld_size_i     (op_q[1:0]),
      .ld_unsigned_i (op_q[LSU_OP_UNSIGNED]),
      .ld_rdata_i    (mem.mem_rdata_i),
      .ld_data_c_o   (ld_data_c)
   );

   // Next-state, request latch and result capture
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      off_d   = off_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      fault_c = (lsu_op_i[1:0] == LSU_SZ_RSVD);
`ifdef LSU_MISALIGN_CHECK_EN
      fault_c = fault_c | lsu_misaligned(lsu_op_i[1:0], addr_i[1:0]);
`endif
      case (state_q)
         ST_IDLE: begin
            if (ex_valid_i && ex_ready_q) begin
               op_d    = lsu_op_i;
               off_d   = addr_i[1:0];
               addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
               we_d    = lsu_op_i[LSU_OP_STORE];
               wdata_d = st_wdata_c;
               wstrb_d = lsu_op_i[LSU_OP_STORE] ? st_wstrb_c : 4'b0000;
               rdata_d = '0;
               err_d   = fault_c;
               state_d = fault_c ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem.mem_req_ready_i) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (mem.mem_resp_valid_i) begin
               err_d   = mem.mem_resp_err_i;
               rdata_d = (mem.mem_resp_err_i || op_q[LSU_OP_STORE]) ? '0 : ld_data_c;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (wb_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      ex_ready_d  = (state_d == ST_IDLE);
      req_valid_d = (state_d == ST_REQ);
      wb_valid_d  = (state_d == ST_DONE);
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         off_q       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         ex_ready_q  <= 1'b1;
         req_valid_q <= 1'b0;
         wb_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         off_q       <= off_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         ex_ready_q  <= ex_ready_d;
         req_valid_q <= req_valid_d;
         wb_valid_q  <= wb_valid_d;
      end
   end

   assign ex_ready_o          = ex_ready_q;
   assign wb_valid_o          = wb_valid_q;
   assign rdata_o             = rdata_q;
   assign err_o               = err_q;
   assign mem.mem_req_valid_o = req_valid_q;
   assign mem.mem_addr_o      = addr_q;
   assign mem.mem_we_o        = we_q;
   assign mem.mem_wdata_o     = wdata_q;
   assign mem.mem_wstrb_o     = wstrb_q;

endmodule

// File: tb/tb_ysyx_25040101_lsu.sv
// Bench for ysyx_25040101_lsu: vector table plus stall and reset sequences.
// Honours LSU_MISALIGN_CHECK_EN when filling expectations.
module tb_ysyx_25040101_lsu;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        rerr;
      logic        skip;
      logic [31:0] e_addr;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic [31:0] e_rd;
      logic        e_err;
   } vec_t;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  op = '0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [31:0] rdata;
   logic        err;

   int   n_chk = 0;
   int   n_fail = 0;
   vec_t vecs[$];
   exp_t sb_q[$];

   always #5 clk = ~clk;

   ysyx_25040101_lsu_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

   ysyx_25040101_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .ex_valid_i (ex_valid),
      .ex_ready_o (ex_ready),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .lsu_op_i   (op),
      .wb_valid_o (wb_valid),
      .wb_ready_i (wb_ready),
      .rdata_o    (rdata),
      .err_o      (err),
      .mem        (mem_if)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input logic re, input logic sk,
                               input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ew,
                               input logic [31:0] erd, input logic ee);
      vec_t v;
      v.op = o; v.addr = a; v.wdata = wd; v.rdata = rd; v.rerr = re; v.skip = sk;
      v.e_addr = ea; v.e_strb = es; v.e_wdata = ew; v.e_rd = erd; v.e_err = ee;
      return v;
   endfunction

   // Check the writeback result against the scoreboard head, then complete the handshake
   task automatic take_result(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk({tag, " scoreboard empty"}, 32'(sb_q.size()), 32'd1);
         return;
      end
      e = sb_q.pop_front();
      chk({tag, " rdata"}, rdata, e.rd);
      chk({tag, " err"}, 32'(err), 32'(e.err));
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      chk({tag, " wb_valid drop"}, 32'(wb_valid), 32'd0);
      chk({tag, " ex_ready back"}, 32'(ex_ready), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      int    cyc;
      int    k;
      tag = $sformatf("vec%0d", idx);
      chk({tag, " ex_ready idle"}, 32'(ex_ready), 32'd1);
      ex_valid = 1'b1; addr = v.addr; op = v.op; wdata = v.wdata;
      sb_q.push_back('{rd: v.e_rd, err: v.e_err});
      @(negedge clk);
      ex_valid = 1'b0;
      cyc = 1;
      chk({tag, " ex_ready busy"}, 32'(ex_ready), 32'd0);
      if (!v.skip) begin
         chk({tag, " req_valid"}, 32'(mem_if.mem_req_valid_o), 32'd1);
         chk({tag, " mem_addr"}, mem_if.mem_addr_o, v.e_addr);
         chk({tag, " we"}, 32'(mem_if.mem_we_o), 32'(v.op[3]));
         chk({tag, " wstrb"}, 32'(mem_if.mem_wstrb_o), 32'(v.e_strb));
         if (v.op[3]) chk({tag, " wdata"}, mem_if.mem_wdata_o, v.e_wdata);
         mem_if.mem_req_ready_i = 1'b1;
         @(negedge clk);
         mem_if.mem_req_ready_i = 1'b0;
         cyc++;
         chk({tag, " req_valid drop"}, 32'(mem_if.mem_req_valid_o), 32'd0);
         mem_if.mem_resp_valid_i = 1'b1;
         mem_if.mem_rdata_i = v.rdata;
         mem_if.mem_resp_err_i = v.rerr;
         @(negedge clk);
         mem_if.mem_resp_valid_i = 1'b0;
         mem_if.mem_resp_err_i = 1'b0;
         mem_if.mem_rdata_i = 32'h5A5A_5A5A;
         cyc++;
      end else begin
         chk({tag, " no bus req"}, 32'(mem_if.mem_req_valid_o), 32'd0);
      end
      k = 0;
      while (wb_valid !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
         cyc++;
      end
      chk({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
      if (!v.skip) chk({tag, " latency"}, 32'(cyc), 32'd3);
      take_result(tag);
   endtask

   initial begin
      mem_if.mem_req_ready_i  = 1'b0;
      mem_if.mem_resp_valid_i = 1'b0;
      mem_if.mem_rdata_i      = '0;
      mem_if.mem_resp_err_i   = 1'b0;

      // op, addr, wdata, mem_rdata, resp_err, skip, exp addr, exp strb, exp wdata, exp rd, exp err
      vecs.push_back(mk(4'b0000, 32'h8000_0003, 32'h0,         32'h80AA_BBCC, 0, 0, 32'h8000_0000, 4'b0000, 32'h0,         32'hFFFF_FF80, 0));
      vecs.push_back(mk(4'b0101, 32'h8000_0002, 32'h0,         32'hBEEF_1234, 0, 0, 32'h8000_0000, 4'b0000, 32'h0,         32'h0000_BEEF, 0));
      vecs.push_back(mk(4'b1000, 32'h0000_1001, 32'h0000_00A5, 32'h0,         0, 0, 32'h0000_1000, 4'b0010, 32'h0000_A500, 32'h0,         0));
      vecs.push_back(mk(4'b0010, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 0, 0, 32'h1000_0004, 4'b0000, 32'h0,         32'hDEAD_BEEF, 0));
      vecs.push_back(mk(4'b0001, 32'h0000_0010, 32'h0,         32'h1234_8001, 0, 0, 32'h0000_0010, 4'b0000, 32'h0,         32'hFFFF_8001, 0));
      vecs.push_back(mk(4'b0100, 32'h0000_0011, 32'h0,         32'h1234_80F1, 0, 0, 32'h0000_0010, 4'b0000, 32'h0,         32'h0000_0080, 0));
      vecs.push_back(mk(4'b1001, 32'h0000_0022, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 32'h0000_0020, 4'b1100, 32'h5678_0000, 32'h0,         0));
      vecs.push_back(mk(4'b1010, 32'h0000_0030, 32'hCAFE_F00D, 32'h0,         0, 0, 32'h0000_0030, 4'b1111, 32'hCAFE_F00D, 32'h0,         0));
      vecs.push_back(mk(4'b0010, 32'h0000_0040, 32'h0,         32'hFFFF_FFFF, 1, 0, 32'h0000_0040, 4'b0000, 32'h0,         32'h0,         1));
      vecs.push_back(mk(4'b1010, 32'h0000_0044, 32'h1111_2222, 32'h0,         1, 0, 32'h0000_0044, 4'b1111, 32'h1111_2222, 32'h0,         1));
      vecs.push_back(mk(4'b0011, 32'h0000_0050, 32'h0,         32'h0,         0, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         1));
      vecs.push_back(mk(4'b1011, 32'h0000_0054, 32'h1234_5678, 32'h0,         0, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         1));
      vecs.push_back(mk(4'b0000, 32'h0000_0002, 32'h0,         32'h007F_0000, 0, 0, 32'h0000_0000, 4'b0000, 32'h0,         32'h0000_007F, 0));
`ifdef LSU_MISALIGN_CHECK_EN
      vecs.push_back(mk(4'b0001, 32'h0000_0003, 32'h0,         32'hAB00_0000, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         1));
      vecs.push_back(mk(4'b1010, 32'h0000_0006, 32'h1122_3344, 32'h0,         0, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         1));
      vecs.push_back(mk(4'b0010, 32'h0000_0002, 32'h0,         32'hBEEF_1234, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0,         1));
`else
      vecs.push_back(mk(4'b0001, 32'h0000_0003, 32'h0,         32'hAB00_0000, 0, 0, 32'h0000_0000, 4'b0000, 32'h0,         32'h0000_00AB, 0));
      vecs.push_back(mk(4'b1010, 32'h0000_0006, 32'h1122_3344, 32'h0,         0, 0, 32'h0000_0004, 4'b1100, 32'h3344_0000, 32'h0,         0));
      vecs.push_back(mk(4'b0010, 32'h0000_0002, 32'h0,         32'hBEEF_1234, 0, 0, 32'h0000_0000, 4'b0000, 32'h0,         32'h0000_BEEF, 0));
`endif

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst ex_ready", 32'(ex_ready), 32'd1);
      chk("rst wb_valid", 32'(wb_valid), 32'd0);
      chk("rst req_valid", 32'(mem_if.mem_req_valid_o), 32'd0);
      chk("rst rdata", rdata, 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst mem_addr", mem_if.mem_addr_o, 32'd0);
      chk("rst we", 32'(mem_if.mem_we_o), 32'd0);
      chk("rst wstrb", 32'(mem_if.mem_wstrb_o), 32'd0);
      chk("rst wdata", mem_if.mem_wdata_o, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table, applied back to back
      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // Request and writeback back-pressure: fields held, execute stalled
      ex_valid = 1'b1; addr = 32'h8000_0008; op = 4'b0010;
      sb_q.push_back('{rd: 32'h1234_5678, err: 1'b0});
      @(negedge clk);
      ex_valid = 1'b0; addr = 32'hFFFF_FFFF; op = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stall%0d req_valid", i), 32'(mem_if.mem_req_valid_o), 32'd1);
         chk($sformatf("stall%0d mem_addr", i), mem_if.mem_addr_o, 32'h8000_0008);
         chk($sformatf("stall%0d we", i), 32'(mem_if.mem_we_o), 32'd0);
         chk($sformatf("stall%0d wstrb", i), 32'(mem_if.mem_wstrb_o), 32'd0);
         chk($sformatf("stall%0d ex_ready", i), 32'(ex_ready), 32'd0);
         @(negedge clk);
      end
      chk("stall req_valid kept", 32'(mem_if.mem_req_valid_o), 32'd1);
      mem_if.mem_req_ready_i = 1'b1;
      @(negedge clk);
      mem_if.mem_req_ready_i = 1'b0;
      @(negedge clk);
      chk("stall resp wait wb_valid", 32'(wb_valid), 32'd0);
      mem_if.mem_resp_valid_i = 1'b1;
      mem_if.mem_rdata_i = 32'h1234_5678;
      @(negedge clk);
      mem_if.mem_resp_valid_i = 1'b0;
      mem_if.mem_rdata_i = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("wbstall%0d wb_valid", i), 32'(wb_valid), 32'd1);
         chk($sformatf("wbstall%0d rdata", i), rdata, 32'h1234_5678);
         chk($sformatf("wbstall%0d err", i), 32'(err), 32'd0);
         chk($sformatf("wbstall%0d ex_ready", i), 32'(ex_ready), 32'd0);
         @(negedge clk);
      end
      take_result("wbstall");

      // Reset while waiting for the response; the late response is ignored
      ex_valid = 1'b1; addr = 32'h0000_0100; op = 4'b0010;
      @(negedge clk);
      ex_valid = 1'b0;
      mem_if.mem_req_ready_i = 1'b1;
      @(negedge clk);
      mem_if.mem_req_ready_i = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_if.mem_resp_valid_i = 1'b1;
      mem_if.mem_rdata_i = 32'hAAAA_5555;
      @(negedge clk);
      mem_if.mem_resp_valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("midrst%0d ex_ready", i), 32'(ex_ready), 32'd1);
         chk($sformatf("midrst%0d wb_valid", i), 32'(wb_valid), 32'd0);
         chk($sformatf("midrst%0d req_valid", i), 32'(mem_if.mem_req_valid_o), 32'd0);
         chk($sformatf("midrst%0d rdata", i), rdata, 32'd0);
         @(negedge clk);
      end

      // Normal operation resumes after the abandoned access
      run_vec(vecs[0], 100);
      chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
